serial_addsub: RTL
==================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter: WIDTH, 8, operand word length in bits; legal range 2..32.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port: clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  asynchronous reset, active low.
REQ-005 Port: start  input  1  begin a new word operation; sampled only in IDLE.
REQ-006 Port: in_valid  input  1  a_bit/b_bit are valid this cycle.
REQ-007 Port: a_bit  input  1  operand A bit, LSB first.
REQ-008 Port: b_bit  input  1  operand B bit, LSB first.
REQ-009 Port: sub  input  1  1 = A-B, 0 = A+B; sampled with start; present only when SUB_EN is defined.
REQ-010 Port: in_ready  output  1  block accepts a bit this cycle; a bit transfers when in_valid & in_ready.
REQ-011 Port: s_bit  output  1  registered result bit, LSB first.
REQ-012 Port: s_valid  output  1  s_bit is valid; one-cycle pulse per accepted bit.
REQ-013 Port: sum  output  WIDTH  parallel result word; holds until the next start.
REQ-014 Port: cout  output  1  final carry (add) or not-borrow (sub); valid from done onwards.
REQ-015 Port: overflow  output  1  signed two's-complement overflow; valid from done onwards.
REQ-016 Port: done  output  1  one-cycle pulse: word complete.
REQ-017 Port: busy  output  1  high in RUN and DONE.

Function
REQ-018 FSM states SHALL be IDLE, RUN and DONE.
REQ-019 IDLE: in_ready=0; in_valid ignored; start=1 -> RUN, bit counter=0, sum=0, carry=mode, mode latched from sub.
REQ-020 RUN: in_ready=1; in_valid=0 -> stall, no state, counter or carry change.
REQ-021 Per accepted bit i: b'=b_bit^mode; s=a_bit^b'^carry; carry<=majority(a_bit,b',carry); sum[i]<=s.
REQ-022 Latency: s_bit/s_valid SHALL appear exactly 1 cycle after the accepting edge; s_valid=0 otherwise.
REQ-023 Carry into bit WIDTH-1 SHALL be captured; overflow = that carry XOR final carry.
REQ-024 Acceptance of bit WIDTH-1 -> DONE; counter never wraps past WIDTH-1.
REQ-025 DONE lasts one cycle: done=1, in_ready=0, cout/overflow/sum final; next state IDLE unconditionally.
REQ-026 The final s_valid pulse SHALL coincide with the done pulse.
REQ-027 start SHALL be ignored in RUN and DONE; start in the IDLE cycle after DONE begins a new word.
REQ-028 cout, overflow and sum SHALL hold their values in IDLE until the next start clears sum.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, counter=0, carry=0, mode=0 and all outputs to 0, including sum.
REQ-030 Reset mid-RUN SHALL abandon the word; no done pulse; the next start begins from bit 0.
REQ-031 After rst_n rises, the first start SHALL be accepted on the first clock edge.

Configuration
REQ-032 Macro SERIAL_ADDSUB_SUB_EN: defined -> sub port present; subtract mode via B inversion and carry-in 1.
REQ-033 SERIAL_ADDSUB_SUB_EN undefined -> sub port absent; mode is constant 0 (add only); all other behaviour identical.

Verification (WIDTH=8)
REQ-034 0x05+0x03, in_valid held 1 -> s_valid 8 consecutive cycles; sum=0x08; cout=0; overflow=0; done at cycle 9 after start.
REQ-035 0xFF+0x01 -> sum=0x00, cout=1, overflow=0.
REQ-036 0x7F+0x01 -> sum=0x80, cout=0, overflow=1.
REQ-037 0x5A+0x33 with in_valid low every other cycle -> sum=0x8D; s_valid only after accepted bits; done after 8th accept.
REQ-038 rst_n low after 4 bits, then new start 0x01+0x01 -> no done for aborted word; sum=0x02.
REQ-039 SUB_EN defined: 0x03-0x05 -> sum=0xFE, cout=0; 0x80-0x01 -> sum=0x7F, cout=1, overflow=1.

Source files
------------

// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
//
// Bit-serial adder/subtractor. Operands arrive LSB first, one bit pair per
// accepted cycle. Each accepted bit produces a registered result bit one
// cycle later, and the result word is also assembled in parallel in `sum`.
// After WIDTH bits the block pulses `done` for one cycle. It reports the
// final carry in `cout` and the signed overflow in `overflow`.
//
// Configuration macro: SERIAL_ADDSUB_SUB_EN
//   defined   -> `sub` port exists. sub=1 computes A-B as A + ~B + 1.
//   undefined -> no `sub` port. The block only adds.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous reset, active low
//   start      in   begin a word (sampled in IDLE only)
//   in_valid   in   a_bit/b_bit valid
//   a_bit      in   operand A bit, LSB first
//   b_bit      in   operand B bit, LSB first
//   sub        in   1 = A-B, 0 = A+B (only with SERIAL_ADDSUB_SUB_EN)
//   in_ready   out  bit accepted when in_valid & in_ready (high in RUN)
//   s_bit      out  registered result bit
//   s_valid    out  one-cycle pulse per accepted bit, 1 cycle after accept
//   sum        out  parallel result, held until the next start
//   cout       out  final carry (add) / not-borrow (sub)
//   overflow   out  signed two's-complement overflow
//   done       out  one-cycle pulse when the word completes
//   busy       out  high in RUN and DONE
//   state_dbg  out  current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
// Handshake: a bit transfers on a rising edge where in_valid & in_ready are
// both high. in_ready does not depend on in_valid. Bits presented while
// in_ready is low are ignored.
// ---------------------------------------------------------------------------
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic             a_bit,
    input  logic             b_bit,
`ifdef SERIAL_ADDSUB_SUB_EN
    input  logic             sub,
`endif
    output logic             in_ready,
    output logic             s_bit,
    output logic             s_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             done,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             mode_q, mode_d;
    logic             s_bit_q, s_bit_d;
    logic             s_valid_q, s_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;

    logic             mode_in;
    logic             b_eff;
    logic             s_now;
    logic             carry_now;

`ifdef SERIAL_ADDSUB_SUB_EN
    assign mode_in = sub;
`else
    assign mode_in = 1'b0;
`endif

    // Subtraction inverts B. The +1 comes from the carry preset at start.
    assign b_eff     = b_bit ^ mode_q;
    assign s_now     = a_bit ^ b_eff ^ carry_q;
    assign carry_now = (a_bit & b_eff) | (a_bit & carry_q) | (b_eff & carry_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        mode_d     = mode_q;
        s_bit_d    = 1'b0;
        s_valid_d  = 1'b0;
        sum_d      = sum_q;
        cout_d     = cout_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    sum_d   = '0;
                    mode_d  = mode_in;
                    carry_d = mode_in;
                end
            end
            RUN: begin
                if (in_valid) begin
                    s_bit_d      = s_now;
                    s_valid_d    = 1'b1;
                    sum_d[cnt_q] = s_now;
                    carry_d      = carry_now;
                    if (cnt_q == LAST) begin
                        // carry_q is the carry into the MSB here. Overflow is
                        // when it differs from the carry out of the MSB.
                        state_d    = DONE;
                        done_d     = 1'b1;
                        cout_d     = carry_now;
                        overflow_d = carry_q ^ carry_now;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            mode_q     <= 1'b0;
            s_bit_q    <= 1'b0;
            s_valid_q  <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            mode_q     <= mode_d;
            s_bit_q    <= s_bit_d;
            s_valid_q  <= s_valid_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign in_ready  = (state_q == RUN);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign state_dbg = state_q;
    assign s_bit     = s_bit_q;
    assign s_valid   = s_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = overflow_q;
    assign done      = done_q;

endmodule
